// File: rtl/hwpf_lifo_dedup.sv
// Prefetch candidate stack: shift-organised LIFO with drop-oldest overflow,
// line-granular deduplication, lock and flush. Entry 0 is always the top.
module hwpf_lifo_dedup #(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_WIDTH  = 40,
    parameter int LINE_OFFSET = 6,
    parameter bit DEDUP_EN    = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic                                 lock_i,
    input  logic                                 push_i,
    input  logic [ADDR_WIDTH-1:0]                val_i,
    input  logic                                 pop_i,
    output logic                                 valid_o,
    output logic [ADDR_WIDTH-1:0]                req_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     count_o,
    output logic                                 full_o,
    output logic                                 drop_o,
    output logic                                 dup_o
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = $clog2(STACK_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] entry_q   [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] entry_nxt [STACK_DEPTH];
    logic [CW-1:0]         count_q, count_nxt;
    logic                  drop_q, drop_nxt;
    logic                  dup_q, dup_nxt;
    logic                  match_hit;
    logic [IW-1:0]         match_idx;
    logic                  full;

    assign full = (count_q == DEPTH_C);

    // Only valid entries can match; duplicates never coexist, so the last hit is the only hit.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int k = 0; k < STACK_DEPTH; k++) begin
            if (DEDUP_EN && (CW'(k) < count_q) &&
                (entry_q[k][ADDR_WIDTH-1:LINE_OFFSET] == val_i[ADDR_WIDTH-1:LINE_OFFSET])) begin
                match_hit = 1'b1;
                match_idx = IW'(k);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        entry_nxt = entry_q;
        count_nxt = count_q;
        drop_nxt  = 1'b0;
        dup_nxt   = 1'b0;

        if (flush_i) begin
            for (int i = 0; i < STACK_DEPTH; i++) entry_nxt[i] = '0;
            count_nxt = '0;
        end else if (lock_i) begin
            // contents frozen; pulses already defaulted low
        end else if (push_i && pop_i) begin
            // Replace top: the popped slot is reused by the new address.
            entry_nxt[0] = val_i;
            if (match_hit) begin
                dup_nxt = 1'b1;
                if (match_idx != '0) begin
                    for (int i = 1; i < STACK_DEPTH - 1; i++) begin
                        if (IW'(i) >= match_idx) entry_nxt[i] = entry_q[i+1];
                    end
                    entry_nxt[STACK_DEPTH-1] = '0;
                    count_nxt = count_q - CW'(1);
                end
            end else if (count_q == '0) begin
                count_nxt = CW'(1);
            end
        end else if (push_i) begin
            // A match only shifts the entries above it; otherwise the whole stack shifts.
            entry_nxt[0] = val_i;
            for (int i = 1; i < STACK_DEPTH; i++) begin
                if (!match_hit || (IW'(i) <= match_idx)) entry_nxt[i] = entry_q[i-1];
            end
            if (match_hit) begin
                dup_nxt = 1'b1;
            end else if (full) begin
                drop_nxt = 1'b1;
            end else begin
                count_nxt = count_q + CW'(1);
            end
        end else if (pop_i && (count_q != '0)) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) entry_nxt[i] = entry_q[i+1];
            entry_nxt[STACK_DEPTH-1] = '0;
            count_nxt = count_q - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    // NOTE: the entry array is reset too, because req_o must read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STACK_DEPTH; i++) entry_q[i] <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            entry_q <= entry_nxt;
            count_q <= count_nxt;
            drop_q  <= drop_nxt;
            dup_q   <= dup_nxt;
        end
    end

    assign valid_o = (count_q != '0);
    assign req_o   = entry_q[0];
    assign count_o = count_q;
    assign full_o  = full;
    assign drop_o  = drop_q;
    assign dup_o   = dup_q;

endmodule

// File: tb/tb_hwpf_lifo_dedup.sv
// Scoreboard bench for hwpf_lifo_dedup (depth 2): stimulus queues expected
// output state, a negedge monitor pops and compares.
module tb_hwpf_lifo_dedup;

    localparam int D  = 2;
    localparam int AW = 40;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] req;
        logic [1:0]    count;
        logic          full;
        logic          drop;
        logic          dup;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          lock_i = 1'b0;
    logic          push_i = 1'b0;
    logic          pop_i = 1'b0;
    logic [AW-1:0] val_i = '0;
    logic          valid_o;
    logic [AW-1:0] req_o;
    logic [1:0]    count_o;
    logic          full_o, drop_o, dup_o;

    int checks = 0;
    int failures = 0;

    exp_t  exp_q  [$];
    string name_q [$];

    hwpf_lifo_dedup #(
        .STACK_DEPTH(D), .ADDR_WIDTH(AW), .LINE_OFFSET(6), .DEDUP_EN(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .lock_i(lock_i),
        .push_i(push_i), .val_i(val_i), .pop_i(pop_i),
        .valid_o(valid_o), .req_o(req_o), .count_o(count_o),
        .full_o(full_o), .drop_o(drop_o), .dup_o(dup_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got valid=%0b req=%h count=%0d full=%0b drop=%0b dup=%0b, expected valid=%0b req=%h count=%0d full=%0b drop=%0b dup=%0b",
                     name, act.valid, act.req, act.count, act.full, act.drop, act.dup,
                     exp.valid, exp.req, exp.count, exp.full, exp.drop, exp.dup);
        end
    endtask

    // Monitor: outputs are registered, so the negedge sees the settled state.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{valid: valid_o, req: req_o, count: count_o, full: full_o, drop: drop_o, dup: dup_o};
            check(n, a, e);
        end
    end

    function automatic exp_t mk(input logic v, input logic [AW-1:0] r, input logic [1:0] c,
                                input logic f, input logic dr, input logic du);
        return '{valid: v, req: r, count: c, full: f, drop: dr, dup: du};
    endfunction

    task automatic expect_now(input string name, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // One clock of stimulus; the expectation describes the state after the edge.
    task automatic step(input string name, input logic push, input logic pop,
                        input logic lock, input logic flush, input logic [AW-1:0] val,
                        input exp_t e);
        @(negedge clk_i);
        #1;
        push_i = push; pop_i = pop; lock_i = lock; flush_i = flush; val_i = val;
        @(posedge clk_i);
        #1;
        push_i = 1'b0; pop_i = 1'b0; lock_i = 1'b0; flush_i = 1'b0; val_i = '0;
        expect_now(name, e);
    endtask

    localparam exp_t EMPTY = '{valid: 1'b0, req: '0, count: 2'd0, full: 1'b0, drop: 1'b0, dup: 1'b0};

    initial begin
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        expect_now("reset_state", EMPTY);

        // 1. basic push/pop and underflow
        step("push_first", 1, 0, 0, 0, 40'hCAFE0001, mk(1, 40'hCAFE0001, 1, 0, 0, 0));
        step("pop_to_empty", 0, 1, 0, 0, '0, EMPTY);
        step("pop_underflow", 0, 1, 0, 0, '0, EMPTY);

        // 2. overflow drops oldest
        step("ovf_push1", 1, 0, 0, 0, 40'hCAFE0040, mk(1, 40'hCAFE0040, 1, 0, 0, 0));
        step("ovf_push2", 1, 0, 0, 0, 40'hCAFE0080, mk(1, 40'hCAFE0080, 2, 1, 0, 0));
        step("ovf_push3", 1, 0, 0, 0, 40'hCAFE00C0, mk(1, 40'hCAFE00C0, 2, 1, 1, 0));
        step("ovf_drop_clears", 0, 0, 0, 0, '0, mk(1, 40'hCAFE00C0, 2, 1, 0, 0));
        step("ovf_pop1", 0, 1, 0, 0, '0, mk(1, 40'hCAFE0080, 1, 0, 0, 0));
        step("ovf_pop2", 0, 1, 0, 0, '0, EMPTY);

        // 3. dedup moves matching line to the top
        step("dd_push1", 1, 0, 0, 0, 40'hCAFE0100, mk(1, 40'hCAFE0100, 1, 0, 0, 0));
        step("dd_push2", 1, 0, 0, 0, 40'hCAFE0140, mk(1, 40'hCAFE0140, 2, 1, 0, 0));
        step("dd_push_match", 1, 0, 0, 0, 40'hCAFE0108, mk(1, 40'hCAFE0108, 2, 1, 0, 1));
        step("dd_pop1", 0, 1, 0, 0, '0, mk(1, 40'hCAFE0140, 1, 0, 0, 0));
        step("dd_pop2", 0, 1, 0, 0, '0, EMPTY);

        // 4. replace-top (push+pop)
        step("rt_empty", 1, 1, 0, 0, 40'hCAFE0200, mk(1, 40'hCAFE0200, 1, 0, 0, 0));
        step("rt_nomatch", 1, 1, 0, 0, 40'hCAFE0240, mk(1, 40'hCAFE0240, 1, 0, 0, 0));
        step("rt_match_top", 1, 1, 0, 0, 40'hCAFE0248, mk(1, 40'hCAFE0248, 1, 0, 0, 1));
        step("rt_fill1", 1, 0, 0, 0, 40'hCAFE0280, mk(1, 40'hCAFE0280, 2, 1, 0, 0));
        step("rt_match_k1", 1, 1, 0, 0, 40'hCAFE0250, mk(1, 40'hCAFE0250, 1, 0, 0, 1));
        step("rt_pop", 0, 1, 0, 0, '0, EMPTY);

        // 5. lock and flush priority
        step("lk_push", 1, 0, 0, 0, 40'hCAFE0300, mk(1, 40'hCAFE0300, 1, 0, 0, 0));
        step("lk_hold", 1, 1, 1, 0, 40'hCAFE0340, mk(1, 40'hCAFE0300, 1, 0, 0, 0));
        step("lk_full_push", 1, 0, 0, 0, 40'hCAFE0380, mk(1, 40'hCAFE0380, 2, 1, 0, 0));
        step("lk_flush", 1, 0, 1, 1, 40'hCAFE03C0, EMPTY);

        // 6. asynchronous reset between edges
        step("ar_push1", 1, 0, 0, 0, 40'hCAFE0400, mk(1, 40'hCAFE0400, 1, 0, 0, 0));
        step("ar_push2", 1, 0, 0, 0, 40'hCAFE0440, mk(1, 40'hCAFE0440, 2, 1, 0, 0));
        @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1 expect_now("async_reset", EMPTY);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        step("after_reset_idle", 0, 0, 0, 0, '0, EMPTY);

        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk_i);
                budget--;
            end
            if (exp_q.size() > 0) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: got %0d pending expectations, expected 0", exp_q.size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
